// File: rtl/keypad_debounce_ctrl.sv
// keypad_debounce_ctrl
// Frame-synchronous debounce for the 4x3 keypad scanner feeding the RAT CPU
// I/O port. A key is accepted after DEB_FRAMES identical full scan frames and
// is not repeated until the keypad reads empty for DEB_FRAMES frames.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_IDLE     | no key being tracked; waiting for a SINGLE frame
//   ST_DEBOUNCE | cand seen for cnt consecutive SINGLE frames
//   ST_HELD     | key accepted; auto-repeat suppressed while anything held
//   ST_RELEASE  | cnt consecutive EMPTY frames seen since key was held
module keypad_debounce_ctrl #(
    parameter int DEB_FRAMES = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] scan_col,
    input  logic       press,
    input  logic [3:0] data,
    input  logic       int_ack,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       intr,
    output logic       overrun
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] COL_FIRST = 4'b1000;
    localparam logic [3:0] COL_LAST  = 4'b0001;
    localparam logic [3:0] DEB_CNT   = 4'(DEB_FRAMES);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] cand;
    logic       synced;

    // per-frame accumulators (state up to, but not including, this cycle)
    logic       acc_hit;
    logic [3:0] acc_code;
    logic       acc_multi;

    logic       col_onehot;
    logic       frame_start;
    logic       frame_end;
    logic       fr_hit;
    logic [3:0] fr_code;
    logic       fr_multi;
    logic       fr_single;
    logic       fr_empty;
    logic [3:0] cnt_inc;
    logic       accept;

    // Frame view that folds in the current cycle, so the frame-end cycle's
    // own press/data take part in the classification.
    always_comb begin
        col_onehot  = $onehot(scan_col);
        frame_start = col_onehot && (scan_col == COL_FIRST);
        frame_end   = col_onehot && (scan_col == COL_LAST) && synced;
        fr_hit      = acc_hit | press;
        fr_code     = acc_hit ? acc_code : data;
        fr_multi    = acc_multi | (acc_hit & press & (data != acc_code));
        fr_single   = fr_hit & ~fr_multi;
        fr_empty    = ~fr_hit;
        cnt_inc     = cnt + 4'd1;
        accept      = frame_end && (state == ST_DEBOUNCE) && fr_single &&
                      (fr_code == cand) && (cnt_inc == DEB_CNT);
    end

    // Column-phase tracking and per-frame press accumulation; a broken
    // (non-one-hot) column word throws the partial frame away.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            synced    <= 1'b0;
            acc_hit   <= 1'b0;
            acc_code  <= 4'd0;
            acc_multi <= 1'b0;
        end else if (!col_onehot) begin
            synced    <= 1'b0;
            acc_hit   <= 1'b0;
            acc_code  <= 4'd0;
            acc_multi <= 1'b0;
        end else if (frame_start) begin
            synced    <= 1'b1;
            acc_hit   <= press;
            acc_code  <= press ? data : 4'd0;
            acc_multi <= 1'b0;
        end else if (synced) begin
            acc_hit   <= fr_hit;
            acc_code  <= fr_hit ? fr_code : acc_code;
            acc_multi <= fr_multi;
        end
    end

    // Debounce FSM with registered key outputs; transitions only at frame end,
    // acknowledge handling runs every cycle and loses to a same-cycle accept.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            intr      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_end) begin
                case (state)
                    ST_IDLE: begin
                        if (fr_single) begin
                            state <= ST_DEBOUNCE;
                            cand  <= fr_code;
                            cnt   <= 4'd1;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (fr_single) begin
                            if (fr_code == cand) begin
                                cnt <= cnt_inc;
                                if (cnt_inc == DEB_CNT) begin
                                    state <= ST_HELD;
                                end
                            end else begin
                                cand <= fr_code;
                                cnt  <= 4'd1;
                            end
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= 4'd0;
                        end
                    end
                    ST_HELD: begin
                        if (fr_empty) begin
                            state <= ST_RELEASE;
                            cnt   <= 4'd1;
                        end
                    end
                    ST_RELEASE: begin
                        if (fr_empty) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == DEB_CNT) begin
                                state <= ST_IDLE;
                                cnt   <= 4'd0;
                            end
                        end else begin
                            state <= ST_HELD;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= 4'd0;
                    end
                endcase
            end

            intr <= accept;
            if (accept) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                overrun   <= int_ack ? 1'b0 : (overrun | key_valid);
            end else if (int_ack) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_debounce_ctrl.sv
// Bench for keypad_debounce_ctrl: directed scenarios plus random frame
// streaks, checked by a scoreboard fed from a frame-level reference model.
module tb_keypad_debounce_ctrl;

    localparam int DEB = 4;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] scan_col;
    logic       press;
    logic [3:0] data;
    logic       int_ack;
    logic [3:0] key_code;
    logic       key_valid;
    logic       intr;
    logic       overrun;

    always #5 CLK = ~CLK;

    keypad_debounce_ctrl #(.DEB_FRAMES(DEB)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .scan_col  (scan_col),
        .press     (press),
        .data      (data),
        .int_ack   (int_ack),
        .key_code  (key_code),
        .key_valid (key_valid),
        .intr      (intr),
        .overrun   (overrun)
    );

    int total = 0;
    int bad   = 0;
    int intr_seen = 0;

    typedef struct packed {
        logic [3:0] code;
        logic       kv;
        logic       ov;
        logic       it;
    } exp_t;

    exp_t       cyc_q[$];
    logic [3:0] ev_q[$];

    // reference model: sync flag, list of presses in the open frame, and
    // run lengths of identical/empty frames
    bit         m_sync;
    logic [3:0] m_presses[$];
    bit         m_armed;
    int         m_run_len;
    logic [3:0] m_run_code;
    int         m_empty_len;
    logic [3:0] m_code;
    bit         m_kv, m_ov, m_intr;

    function automatic void model_reset();
        m_sync = 0;
        m_presses.delete();
        m_armed = 1;
        m_run_len = 0;
        m_run_code = 4'd0;
        m_empty_len = 0;
        m_code = 4'd0;
        m_kv = 0;
        m_ov = 0;
        m_intr = 0;
    endfunction

    task automatic tick(input bit rn, input logic [3:0] col, input bit pr,
                        input logic [3:0] d, input bit ack);
        bit         fend;
        bit         accepted;
        bit         is_empty, is_single;
        logic [3:0] fc;
        RST_N    = rn;
        scan_col = col;
        press    = pr;
        data     = d;
        int_ack  = ack;
        fend     = 0;
        accepted = 0;
        fc       = 4'd0;
        m_intr   = 0;
        if (!rn) begin
            model_reset();
        end else begin
            if ($countones(col) != 1) begin
                m_sync = 0;
                m_presses.delete();
            end else if (col == 4'b1000) begin
                m_sync = 1;
                m_presses.delete();
                if (pr) m_presses.push_back(d);
            end else if (m_sync) begin
                if (pr) m_presses.push_back(d);
                if (col == 4'b0001) fend = 1;
            end
            if (fend) begin
                is_empty  = (m_presses.size() == 0);
                fc        = is_empty ? 4'd0 : m_presses[0];
                is_single = !is_empty;
                foreach (m_presses[k]) if (m_presses[k] != fc) is_single = 0;
                if (m_armed) begin
                    if (is_single) begin
                        if (m_run_len > 0 && fc == m_run_code) m_run_len++;
                        else begin
                            m_run_code = fc;
                            m_run_len  = 1;
                        end
                        if (m_run_len == DEB) begin
                            accepted    = 1;
                            m_armed     = 0;
                            m_empty_len = 0;
                        end
                    end else begin
                        m_run_len = 0;
                    end
                end else begin
                    if (is_empty) begin
                        m_empty_len++;
                        if (m_empty_len == DEB) begin
                            m_armed   = 1;
                            m_run_len = 0;
                        end
                    end else begin
                        m_empty_len = 0;
                    end
                end
            end
            if (accepted) begin
                m_ov   = ack ? 1'b0 : (m_ov | m_kv);
                m_kv   = 1;
                m_code = fc;
                m_intr = 1;
                ev_q.push_back(fc);
            end else if (ack) begin
                m_kv = 0;
                m_ov = 0;
            end
        end
        cyc_q.push_back('{m_code, m_kv, m_ov, m_intr});
        @(posedge CLK);
        #1;
    endtask

    task automatic frame(input logic [3:0] pm, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3, input logic [3:0] am);
        logic [3:0] dv [4];
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] col;
            col = 4'b1000 >> i;
            tick(1'b1, col, pm[i], pm[i] ? dv[i] : 4'd13, am[i]);
        end
    endtask

    task automatic key_frame(input logic [3:0] c, input logic [3:0] am);
        logic [3:0] pm;
        pm = 4'($urandom_range(1, 15));
        frame(pm, c, c, c, c, am);
    endtask

    task automatic empty_frame(input logic [3:0] am);
        frame(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, am);
    endtask

    task automatic multi_frame(input logic [3:0] c1, input logic [3:0] c2);
        frame(4'b0101, c1, c1, c2, c2, 4'b0000);
    endtask

    task automatic settle();
        @(negedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // ack and release so the next scenario starts from a clean HELD-free state
    task automatic clean_up();
        empty_frame(4'b0001);
        for (int i = 0; i < DEB; i++) empty_frame(4'b0000);
    endtask

    // monitor: pops the expected per-cycle output state and each accept event
    exp_t       mon_e;
    logic [3:0] mon_c;
    initial begin
        forever begin
            @(negedge CLK);
            if (cyc_q.size() > 0) begin
                mon_e = cyc_q.pop_front();
                total++;
                if ({key_code, key_valid, overrun, intr} !== mon_e) begin
                    bad++;
                    $display("FAIL cycle_state t=%0t got code=%0d kv=%b ov=%b intr=%b want code=%0d kv=%b ov=%b intr=%b",
                             $time, key_code, key_valid, overrun, intr,
                             mon_e.code, mon_e.kv, mon_e.ov, mon_e.it);
                end
            end
            if (intr === 1'b1) begin
                intr_seen++;
                total++;
                if (ev_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_intr t=%0t got code=%0d want no interrupt", $time, key_code);
                end else begin
                    mon_c = ev_q.pop_front();
                    if (key_code !== mon_c) begin
                        bad++;
                        $display("FAIL accept_code t=%0t got %0d want %0d", $time, key_code, mon_c);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        logic [3:0] cur;
        model_reset();
        RST_N = 1'b0; scan_col = 4'b0000; press = 1'b0; data = 4'd13; int_ack = 1'b0;

        // reset held while key 5 is down, released on a 0010 cycle
        tick(1'b0, 4'b1000, 1'b1, 4'd5, 1'b0);
        tick(1'b0, 4'b0100, 1'b1, 4'd5, 1'b0);
        settle();
        check("reset_key_valid", int'(key_valid), 0);
        check("reset_intr", int'(intr), 0);
        base = intr_seen;
        tick(1'b1, 4'b0010, 1'b1, 4'd5, 1'b0);
        tick(1'b1, 4'b0001, 1'b1, 4'd5, 1'b0);
        for (int i = 0; i < DEB - 1; i++) key_frame(4'd5, 4'b0000);
        settle();
        check("midframe_no_early_intr", intr_seen - base, 0);
        key_frame(4'd5, 4'b0000);
        settle();
        check("midframe_intr_count", intr_seen - base, 1);
        check("midframe_key_code", int'(key_code), 5);
        clean_up();

        // bounce: 2 frames, gap, 4 frames
        base = intr_seen;
        key_frame(4'd7, 4'b0000);
        key_frame(4'd7, 4'b0000);
        empty_frame(4'b0000);
        for (int i = 0; i < DEB; i++) key_frame(4'd7, 4'b0000);
        settle();
        check("bounce_intr_count", intr_seen - base, 1);
        check("bounce_key_code", int'(key_code), 7);
        clean_up();

        // auto-repeat suppression
        base = intr_seen;
        for (int i = 0; i < 20; i++) key_frame(4'd0, 4'b0000);
        settle();
        check("repeat_intr_count", intr_seen - base, 1);
        check("repeat_key_valid", int'(key_valid), 1);
        for (int i = 0; i < DEB - 1; i++) empty_frame(4'b0000);
        for (int i = 0; i < DEB; i++) key_frame(4'd0, 4'b0000);
        settle();
        check("repeat_short_release", intr_seen - base, 1);
        for (int i = 0; i < DEB; i++) empty_frame(4'b0000);
        for (int i = 0; i < DEB; i++) key_frame(4'd0, 4'b0000);
        settle();
        check("repeat_after_release", intr_seen - base, 2);
        clean_up();

        // overrun then acknowledge
        for (int i = 0; i < DEB; i++) key_frame(4'd3, 4'b0000);
        for (int i = 0; i < DEB; i++) empty_frame(4'b0000);
        for (int i = 0; i < DEB; i++) key_frame(4'd11, 4'b0000);
        settle();
        check("overrun_key_code", int'(key_code), 11);
        check("overrun_flag", int'(overrun), 1);
        tick(1'b1, 4'b1000, 1'b0, 4'd13, 1'b1);
        settle();
        check("ack_clears_valid", int'(key_valid), 0);
        check("ack_clears_overrun", int'(overrun), 0);
        tick(1'b1, 4'b0100, 1'b0, 4'd13, 1'b0);
        tick(1'b1, 4'b0010, 1'b0, 4'd13, 1'b0);
        tick(1'b1, 4'b0001, 1'b0, 4'd13, 1'b0);
        clean_up();

        // acknowledge coincident with the second acceptance
        for (int i = 0; i < DEB; i++) key_frame(4'd4, 4'b0000);
        for (int i = 0; i < DEB; i++) empty_frame(4'b0000);
        for (int i = 0; i < DEB - 1; i++) key_frame(4'd9, 4'b0000);
        key_frame(4'd9, 4'b1000);
        settle();
        check("simack_key_valid", int'(key_valid), 1);
        check("simack_overrun", int'(overrun), 0);
        check("simack_key_code", int'(key_code), 9);
        clean_up();

        // multi-key frame during debounce
        base = intr_seen;
        key_frame(4'd1, 4'b0000);
        key_frame(4'd1, 4'b0000);
        multi_frame(4'd1, 4'd2);
        key_frame(4'd1, 4'b0000);
        key_frame(4'd1, 4'b0000);
        empty_frame(4'b0000);
        settle();
        check("multi_no_intr", intr_seen - base, 0);

        // reset while HELD, key still down afterwards
        for (int i = 0; i < DEB + 1; i++) key_frame(4'd6, 4'b0000);
        tick(1'b0, 4'b1000, 1'b1, 4'd6, 1'b0);
        settle();
        check("held_reset_valid", int'(key_valid), 0);
        check("held_reset_code", int'(key_code), 0);
        check("held_reset_intr", int'(intr), 0);
        check("held_reset_overrun", int'(overrun), 0);
        base = intr_seen;
        tick(1'b1, 4'b0100, 1'b1, 4'd6, 1'b0);
        tick(1'b1, 4'b0010, 1'b1, 4'd6, 1'b0);
        tick(1'b1, 4'b0001, 1'b1, 4'd6, 1'b0);
        for (int i = 0; i < DEB; i++) key_frame(4'd6, 4'b0000);
        settle();
        check("held_reset_reaccept", intr_seen - base, 1);
        clean_up();

        // column glitch mid-debounce: partial frame dropped, count kept
        base = intr_seen;
        key_frame(4'd8, 4'b0000);
        key_frame(4'd8, 4'b0000);
        tick(1'b1, 4'b1000, 1'b1, 4'd8, 1'b0);
        tick(1'b1, 4'b0110, 1'b1, 4'd8, 1'b0);
        tick(1'b1, 4'b0010, 1'b1, 4'd8, 1'b0);
        tick(1'b1, 4'b0001, 1'b1, 4'd8, 1'b0);
        key_frame(4'd8, 4'b0000);
        settle();
        check("glitch_no_early_intr", intr_seen - base, 0);
        key_frame(4'd8, 4'b0000);
        settle();
        check("glitch_intr_count", intr_seen - base, 1);
        clean_up();

        // random streaks of frames with sparse acks, glitches and resets
        cur = 4'd2;
        for (int s = 0; s < 300; s++) begin
            int kind, len;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 7);
            if ($urandom_range(0, 2) == 0) cur = 4'($urandom_range(0, 11));
            for (int f = 0; f < len; f++) begin
                logic [3:0] am;
                am = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
                if (kind <= 3) empty_frame(am);
                else if (kind <= 8) key_frame(cur, am);
                else multi_frame(cur, 4'((cur + 4'd1) % 12));
            end
            if ($urandom_range(0, 29) == 0) tick(1'b1, 4'b0011, 1'b1, cur, 1'b0);
            if ($urandom_range(0, 99) == 0) tick(1'b0, 4'b1000, 1'b0, 4'd13, 1'b0);
        end

        empty_frame(4'b0000);
        settle();
        check("pending_cycle_expectations", cyc_q.size(), 0);
        check("missing_intr_events", ev_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_debounce_ctrl.md
# keypad_debounce_ctrl

Frame-synchronous debounce and key-event controller that sits between the 4x3 keypad column scanner and the RAT CPU I/O port. It tracks the scanner's column phase, accepts a key only after it reads identically for `DEB_FRAMES` consecutive full scan frames, and latches the key code. It then raises a CPU interrupt pulse and suppresses auto-repeat until the key has been released for `DEB_FRAMES` frames.

## Interface
- `DEB_FRAMES`, default 4: number of consecutive identical frames required to accept a key, and number of consecutive empty frames required to confirm release. Legal range is 2..15.
- `CLK` in 1: system clock; all logic is rising-edge.
- `RST_N` in 1: reset, synchronous and active-low.
- `scan_col` in 4: scanner column drives `{B,G,F,D}`, one-hot while the scanner runs.
- `press` in 1: scanner reports that a row is active in the current column.
- `data` in 4: scanner key code, 0-11. The value is ignored when `press`=0; 13 is the scanner's no-key sentinel.
- `int_ack` in 1: CPU acknowledge, a one-cycle pulse.
- `key_code` out 4: last accepted key code, held until the next acceptance.
- `key_valid` out 1: an unacknowledged key is present.
- `intr` out 1: one-cycle interrupt pulse on each acceptance.
- `overrun` out 1: sticky; set when a key is accepted while `key_valid`=1.

## Operation
- Frame definition:
  - A frame is the four cycles `scan_col` = 1000, 0100, 0010, 0001.
  - The frame ends on the 0001 cycle.
- Synchronization:
  - After reset, `synced`=0. Cycles are ignored until `scan_col`=1000 is seen; that cycle starts the first frame and sets `synced`=1.
  - A non-one-hot `scan_col` drops `synced` to 0 and discards the current frame.
  - A non-one-hot `scan_col` does not change the FSM state or the counter.
- Per-frame accumulation, cleared at the start of each frame:
  - `hit`: set when any cycle in the frame has `press`=1.
  - `code`: the `data` value on the first press in the frame.
  - `multi`: set if a later press in the same frame carries a different `data` value.
- Frame classification at frame end:
  - EMPTY: `hit`=0.
  - SINGLE(c): `hit`=1, `multi`=0, code c.
  - MULTI: `hit`=1, `multi`=1.
- FSM states are IDLE, DEBOUNCE, HELD and RELEASE. `cnt` is 4 bits. Transitions are evaluated only at frame end:
  - IDLE:
    - SINGLE(c) → DEBOUNCE, with `cand`=c and `cnt`=1.
    - Otherwise stay in IDLE.
  - DEBOUNCE:
    - SINGLE(`cand`) → `cnt`+1. If `cnt`+1 = `DEB_FRAMES`, ACCEPT and go to HELD.
    - SINGLE(c≠`cand`) → `cand`=c, `cnt`=1.
    - EMPTY or MULTI → IDLE.
  - HELD:
    - SINGLE or MULTI → stay in HELD.
    - EMPTY → RELEASE with `cnt`=1.
  - RELEASE:
    - EMPTY → `cnt`+1. If `cnt`+1 = `DEB_FRAMES`, go to IDLE.
    - SINGLE or MULTI → HELD.
- ACCEPT action, all taking effect on the same edge:
  - `key_code`←`cand`.
  - `key_valid`←1.
  - `intr`←1 for one cycle.
  - `overrun`←1 if `key_valid` was already 1 and `int_ack` is not asserted in that cycle.
- `int_ack`=1 clears `key_valid` and `overrun` on the next edge.
  - If ACCEPT occurs in the same cycle as `int_ack`, ACCEPT wins: `key_valid`=1 and `overrun` is unchanged from 0.
  - `int_ack` has no effect on the FSM.

## Timing
- Reset values: `key_code`=0, `key_valid`=0, `intr`=0, `overrun`=0. Internal state: FSM=IDLE, `cnt`=0, `cand`=0, `synced`=0, frame accumulators cleared.
- Reset asserted mid-debounce or mid-hold:
  - All state returns to the reset values on that edge.
  - A key still held afterwards is re-debounced from IDLE, so it is accepted once more.
- All outputs are registered; there are no combinational input-to-output paths.
- Acceptance latency:
  - Outputs update on the edge that closes the frame-end cycle of the `DEB_FRAMES`-th consecutive SINGLE frame.
  - They are visible on the following cycle.
  - With a steady key and synchronized frames, acceptance follows the first press cycle by at most 4·`DEB_FRAMES` cycles.
- `intr` is high exactly one cycle per acceptance. `key_valid` remains high until acknowledged.
- Frame-end evaluation includes the frame-end cycle's own `press`/`data`.

## Test plan
- Synchronization with a mid-frame start: release reset on a 0010 cycle while key 5 is held. The partial frame is ignored; with `DEB_FRAMES`=4, `intr` pulses once at the end of the 4th full frame and `key_code`=5.
- Bounce: key 7 is present for 2 frames, absent for 1 frame, then present for 4 frames. Exactly one `intr`, occurring after the last 4 frames; `key_code`=7.
- Auto-repeat suppression: hold key 0 for 20 frames. A single `intr`; `key_valid` stays 1; no second acceptance until after 4 EMPTY frames.
- Overrun: accept key 3 without `int_ack`, release, then accept key 11. Result is `key_code`=11, `overrun`=1. An `int_ack` pulse then clears `key_valid` and `overrun` on the next edge.
- Simultaneous acknowledge: assert `int_ack` in the same cycle as the second acceptance. Result is `key_valid`=1, `overrun`=0, `key_code` = new key.
- Multi-key and reset: keys 1 and 2 are both pressed in one frame (MULTI) during DEBOUNCE, which returns the FSM to IDLE with no `intr`. A separate case asserts `RST_N`=0 while in HELD: all outputs are 0 on the next cycle.
